// File: rtl/axi4_lite_slave_read_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite slave read port (AR + R) among
// NUM_MASTERS requesters, with one transaction in flight at a time.
module axi4_lite_slave_read_arbiter #(
   parameter int NUM_MASTERS   = 2,
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   localparam int GRANT_WIDTH  = $clog2(NUM_MASTERS)
) (
   input  logic                              aclk,
   input  logic                              areset,
   input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_araddr,
   input  logic [NUM_MASTERS*3-1:0]          m_arprot,
   input  logic [NUM_MASTERS-1:0]            m_arvalid,
   output logic [NUM_MASTERS-1:0]            m_arready,
   output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
   output logic [NUM_MASTERS*2-1:0]          m_rresp,
   output logic [NUM_MASTERS-1:0]            m_rvalid,
   input  logic [NUM_MASTERS-1:0]            m_rready,
   output logic [ADDRESS_WIDTH-1:0]          s_araddr,
   output logic [2:0]                        s_arprot,
   output logic                              s_arvalid,
   input  logic                              s_arready,
   input  logic [DATA_WIDTH-1:0]             s_rdata,
   input  logic [1:0]                        s_rresp,
   input  logic                              s_rvalid,
   output logic                              s_rready,
   output logic [GRANT_WIDTH-1:0]            grant,
   output logic                              busy
);

   localparam int CW = GRANT_WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t                   state_reg, state_next;
   logic [GRANT_WIDTH-1:0]   grant_reg, grant_next;
   logic [GRANT_WIDTH-1:0]   last_grant_reg, last_grant_next;
   logic [ADDRESS_WIDTH-1:0] araddr_reg, araddr_next;
   logic [2:0]               arprot_reg, arprot_next;
   logic                     arvalid_reg, arvalid_next;

   logic [ADDRESS_WIDTH-1:0] addr_slice [NUM_MASTERS];
   logic [2:0]               prot_slice [NUM_MASTERS];

   logic                     win_found;
   logic [GRANT_WIDTH-1:0]   win_idx;
   logic [CW-1:0]            cand;
   logic                     ar_accept;
   logic                     in_data;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_slice
         assign addr_slice[gi] = m_araddr[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH];
         assign prot_slice[gi] = m_arprot[gi*3 +: 3];
      end
   endgenerate

   // Search upward from last_grant+1, wrapping, so the previous owner goes last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         cand = {1'b0, last_grant_reg} + CW'(k);
         if (cand >= CW'(NUM_MASTERS))
            cand = cand - CW'(NUM_MASTERS);
         if (!win_found && m_arvalid[cand[GRANT_WIDTH-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[GRANT_WIDTH-1:0];
         end
      end
   end

   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      last_grant_next = last_grant_reg;
      araddr_next     = araddr_reg;
      arprot_next     = arprot_reg;
      arvalid_next    = arvalid_reg;
      ar_accept       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (win_found) begin
               ar_accept    = 1'b1;
               araddr_next  = addr_slice[win_idx];
               arprot_next  = prot_slice[win_idx];
               arvalid_next = 1'b1;
               grant_next   = win_idx;
               state_next   = ADDR;
            end
         end
         ADDR: begin
            if (s_arready) begin
               arvalid_next = 1'b0;
               state_next   = DATA;
            end
         end
         DATA: begin
            if (s_rvalid && m_rready[grant_reg]) begin
               last_grant_next = grant_reg;
               state_next      = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_reg      <= IDLE;
         grant_reg      <= '0;
         last_grant_reg <= GRANT_WIDTH'(NUM_MASTERS - 1);
         araddr_reg     <= '0;
         arprot_reg     <= '0;
         arvalid_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         last_grant_reg <= last_grant_next;
         araddr_reg     <= araddr_next;
         arprot_reg     <= arprot_next;
         arvalid_reg    <= arvalid_next;
      end
   end

   // Combinational outputs are forced low while reset is asserted.
   assign in_data   = (state_reg == DATA) && !areset;
   assign s_rready  = in_data && m_rready[grant_reg];
   assign busy      = (state_reg != IDLE) && !areset;
   assign s_araddr  = araddr_reg;
   assign s_arprot  = arprot_reg;
   assign s_arvalid = arvalid_reg;
   assign grant     = grant_reg;

   generate
      for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_route
         logic owner;
         assign owner         = in_data && (grant_reg == GRANT_WIDTH'(gi));
         assign m_arready[gi] = ar_accept && !areset && (win_idx == GRANT_WIDTH'(gi));
         assign m_rvalid[gi]  = owner && s_rvalid;
         assign m_rdata[gi*DATA_WIDTH +: DATA_WIDTH] = owner ? s_rdata : '0;
         assign m_rresp[gi*2 +: 2] = owner ? s_rresp : 2'b00;
      end
   endgenerate

endmodule

// File: tb/tb_axi4_lite_slave_read_arbiter.sv
// Self-checking bench for axi4_lite_slave_read_arbiter (4 requesters): a
// cycle-vector table plus hand sequences, with an AR/R scoreboard.
module tb_axi4_lite_slave_read_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int GW = 2;

   logic            aclk = 1'b0;
   logic            areset = 1'b1;
   logic [N*AW-1:0] m_araddr;
   logic [N*3-1:0]  m_arprot;
   logic [N-1:0]    m_arvalid, m_arready, m_rvalid, m_rready;
   logic [N*DW-1:0] m_rdata;
   logic [N*2-1:0]  m_rresp;
   logic [AW-1:0]   s_araddr;
   logic [2:0]      s_arprot;
   logic            s_arvalid, s_arready;
   logic [DW-1:0]   s_rdata;
   logic [1:0]      s_rresp;
   logic            s_rvalid, s_rready;
   logic [GW-1:0]   grant;
   logic            busy;

   axi4_lite_slave_read_arbiter #(
      .NUM_MASTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)
   ) dut (
      .aclk(aclk), .areset(areset),
      .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid),
      .m_arready(m_arready), .m_rdata(m_rdata), .m_rresp(m_rresp),
      .m_rvalid(m_rvalid), .m_rready(m_rready),
      .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid),
      .s_arready(s_arready), .s_rdata(s_rdata), .s_rresp(s_rresp),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .grant(grant), .busy(busy)
   );

   always #5 aclk = ~aclk;

   // Slave read data is a fixed function of the address it was given.
   function automatic logic [31:0] data_of(input logic [31:0] a);
      return (a == 32'h40) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
   endfunction

   function automatic logic [2:0] prot_of(input int i);
      return 3'(i + 1);
   endfunction

   always_comb s_rdata = data_of(s_araddr);

   typedef struct {
      int          master;
      logic [31:0] addr;
      logic [2:0]  prot;
      logic [31:0] data;
      logic [1:0]  resp;
   } txn_t;

   typedef struct {
      logic [N-1:0] arvalid;
      logic         arready_s;
      logic         rvalid_s;
      logic [N-1:0] rready;
      logic [1:0]   resp;
      int           push_m;
      logic [N-1:0] e_arready;
      logic         e_s_arvalid;
      logic         e_busy;
      logic [N-1:0] e_rvalid;
      logic         e_s_rready;
   } vec_t;

   txn_t ar_q[$];
   txn_t r_q[$];
   txn_t mon_t;
   vec_t vecs[14];
   int   errors = 0;
   int   checks = 0;
   int   txn_count = 0;
   int   rvalid0_cycles = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic set_addr(input int i, input logic [31:0] a);
      m_araddr[i*AW +: AW] = a;
   endtask

   task automatic expect_txn(input int m, input logic [1:0] resp, input bit with_r);
      txn_t t;
      t.master = m;
      t.addr   = m_araddr[m*AW +: AW];
      t.prot   = m_arprot[m*3 +: 3];
      t.data   = data_of(t.addr);
      t.resp   = resp;
      ar_q.push_back(t);
      if (with_r) r_q.push_back(t);
   endtask

   function automatic vec_t mkv(input logic [N-1:0] arv, input logic ars, input logic rvs,
                                input logic [N-1:0] rr, input logic [1:0] resp, input int pm,
                                input logic [N-1:0] e_ar, input logic e_sarv, input logic e_b,
                                input logic [N-1:0] e_rv, input logic e_srr);
      vec_t v;
      v.arvalid = arv; v.arready_s = ars; v.rvalid_s = rvs; v.rready = rr; v.resp = resp;
      v.push_m = pm; v.e_arready = e_ar; v.e_s_arvalid = e_sarv; v.e_busy = e_b;
      v.e_rvalid = e_rv; v.e_s_rready = e_srr;
      return v;
   endfunction

   // Scoreboard monitor: slave AR handshakes and requester R handshakes.
   always @(negedge aclk) begin
      if (!areset) begin
         chk("arready_onehot0", 64'($onehot0(m_arready)), 64'd1);
         chk("rvalid_onehot0", 64'($onehot0(m_rvalid)), 64'd1);
         if (m_rvalid[0]) rvalid0_cycles++;
         if (s_arvalid && s_arready) begin
            if (ar_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL ar_unexpected: got addr 0x%0h, expected no AR", s_araddr);
            end else begin
               mon_t = ar_q.pop_front();
               chk("ar_addr", 64'(s_araddr), 64'(mon_t.addr));
               chk("ar_prot", 64'(s_arprot), 64'(mon_t.prot));
               chk("ar_grant", 64'(grant), 64'(mon_t.master));
            end
         end
         for (int i = 0; i < N; i++) begin
            if (m_rvalid[i] && m_rready[i]) begin
               if (r_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL r_unexpected: got R on master %0d, expected none", i);
               end else begin
                  mon_t = r_q.pop_front();
                  txn_count++;
                  $display("txn %0d: master=%0d addr=0x%08h data=0x%08h resp=%02b",
                           txn_count, i, mon_t.addr, m_rdata[i*DW +: DW], m_rresp[i*2 +: 2]);
                  chk("r_master", 64'(i), 64'(mon_t.master));
                  chk("r_data", 64'(m_rdata[i*DW +: DW]), 64'(mon_t.data));
                  chk("r_resp", 64'(m_rresp[i*2 +: 2]), 64'(mon_t.resp));
                  chk("r_slave_hs", 64'(s_rvalid && s_rready), 64'd1);
               end
            end
         end
      end
   end

   task automatic do_reset();
      tick();
      areset = 1'b1;
      m_arvalid = '0;
      tick();
      areset = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int c = 0; c < 40 && (ar_q.size() != 0 || r_q.size() != 0); c++) tick();
      chk(name, 64'(ar_q.size() + r_q.size()), 64'd0);
   endtask

   // Hold requests, count grants, drop one requester after its first grant.
   task automatic run_rr(input int n, input logic [N-1:0] req, input int drop_idx);
      int seen = 0;
      int last = 0;
      logic [N-1:0] drop;
      m_arvalid = req;
      for (int c = 0; c < 10*n && seen < n; c++) begin
         settle();
         drop = '0;
         if (m_arready != '0) begin
            if (seen > 0) chk("rr_period", 64'(c - last), 64'd3);
            last = c;
            seen++;
            if (drop_idx >= 0 && m_arready[drop_idx]) drop[drop_idx] = 1'b1;
         end
         tick();
         m_arvalid = (seen >= n) ? '0 : (m_arvalid & ~drop);
      end
      m_arvalid = '0;
      chk("rr_grant_count", 64'(seen), 64'(n));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      m_araddr  = '0;
      for (int i = 0; i < N; i++) m_arprot[i*3 +: 3] = prot_of(i);
      m_arvalid = '1;
      m_rready  = '1;
      s_arready = 1'b1;
      s_rvalid  = 1'b1;
      s_rresp   = 2'b00;

      // Reset: combinational outputs gated, registers cleared.
      repeat (2) @(posedge aclk);
      #2;
      chk("rst_arready", 64'(m_arready), 64'd0);
      chk("rst_rvalid", 64'(m_rvalid), 64'd0);
      chk("rst_srready", 64'(s_rready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_sarvalid", 64'(s_arvalid), 64'd0);
      chk("rst_saraddr", 64'(s_araddr), 64'd0);
      chk("rst_sarprot", 64'(s_arprot), 64'd0);
      chk("rst_grant", 64'(grant), 64'd0);
      @(posedge aclk);
      #1;
      areset = 1'b0;
      m_arvalid = '0;
      s_rvalid = 1'b0;

      // Cycle-accurate vectors: single request, delayed slave, wrap to master 3.
      set_addr(0, 32'h40); set_addr(1, 32'h44); set_addr(2, 32'h48); set_addr(3, 32'h4C);
      vecs[0]  = mkv(4'b0000, 1, 0, 4'b1111, 2'b00, -1, 4'b0000, 0, 0, 4'b0000, 0);
      vecs[1]  = mkv(4'b0001, 1, 0, 4'b1111, 2'b00,  0, 4'b0001, 0, 0, 4'b0000, 0);
      vecs[2]  = mkv(4'b0000, 1, 1, 4'b1111, 2'b00, -1, 4'b0000, 1, 1, 4'b0000, 0);
      vecs[3]  = mkv(4'b0000, 1, 1, 4'b1111, 2'b00, -1, 4'b0000, 0, 1, 4'b0001, 1);
      vecs[4]  = mkv(4'b0000, 1, 0, 4'b1111, 2'b00, -1, 4'b0000, 0, 0, 4'b0000, 0);
      vecs[5]  = mkv(4'b0100, 0, 0, 4'b1111, 2'b11,  2, 4'b0100, 0, 0, 4'b0000, 0);
      vecs[6]  = mkv(4'b0000, 0, 0, 4'b1111, 2'b11, -1, 4'b0000, 1, 1, 4'b0000, 0);
      vecs[7]  = mkv(4'b0000, 1, 0, 4'b1111, 2'b11, -1, 4'b0000, 1, 1, 4'b0000, 0);
      vecs[8]  = mkv(4'b0000, 1, 0, 4'b1011, 2'b11, -1, 4'b0000, 0, 1, 4'b0000, 0);
      vecs[9]  = mkv(4'b0000, 1, 1, 4'b1111, 2'b11, -1, 4'b0000, 0, 1, 4'b0100, 1);
      vecs[10] = mkv(4'b1111, 1, 0, 4'b1111, 2'b01,  3, 4'b1000, 0, 0, 4'b0000, 0);
      vecs[11] = mkv(4'b0000, 1, 0, 4'b1111, 2'b01, -1, 4'b0000, 1, 1, 4'b0000, 0);
      vecs[12] = mkv(4'b0000, 1, 1, 4'b1111, 2'b01, -1, 4'b0000, 0, 1, 4'b1000, 1);
      vecs[13] = mkv(4'b0000, 1, 0, 4'b1111, 2'b01, -1, 4'b0000, 0, 0, 4'b0000, 0);
      for (int i = 0; i < 14; i++) begin
         tick();
         m_arvalid = vecs[i].arvalid;
         s_arready = vecs[i].arready_s;
         s_rvalid  = vecs[i].rvalid_s;
         m_rready  = vecs[i].rready;
         s_rresp   = vecs[i].resp;
         if (vecs[i].push_m >= 0) expect_txn(vecs[i].push_m, vecs[i].resp, 1'b1);
         settle();
         chk($sformatf("vec%0d_arready", i), 64'(m_arready), 64'(vecs[i].e_arready));
         chk($sformatf("vec%0d_sarvalid", i), 64'(s_arvalid), 64'(vecs[i].e_s_arvalid));
         chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
         chk($sformatf("vec%0d_rvalid", i), 64'(m_rvalid), 64'(vecs[i].e_rvalid));
         chk($sformatf("vec%0d_srready", i), 64'(s_rready), 64'(vecs[i].e_s_rready));
      end
      wait_drain("vec_drain");

      // Two-master contention: 0x10,0x20,0x10,0x20 at the minimum period.
      do_reset();
      set_addr(0, 32'h10); set_addr(1, 32'h20);
      s_arready = 1'b1; s_rvalid = 1'b1; m_rready = '1; s_rresp = 2'b00;
      for (int k = 0; k < 4; k++) expect_txn(k % 2, 2'b00, 1'b1);
      run_rr(4, 4'b0011, -1);
      wait_drain("rr2_drain");

      // Slave AR backpressure: s_arready low 4 cycles.
      do_reset();
      set_addr(0, 32'h80); set_addr(1, 32'h84);
      s_arready = 1'b0; s_rvalid = 1'b1; m_rready = '1;
      expect_txn(0, 2'b00, 1'b1);
      expect_txn(1, 2'b00, 1'b1);
      m_arvalid = 4'b0011;
      settle();
      chk("bp_first_grant", 64'(m_arready), 64'b0001);
      tick();
      m_arvalid = 4'b0010;
      for (int k = 0; k < 5; k++) begin
         if (k == 4) s_arready = 1'b1;
         settle();
         chk($sformatf("bp_sarvalid_%0d", k), 64'(s_arvalid), 64'd1);
         chk($sformatf("bp_saraddr_%0d", k), 64'(s_araddr), 64'h80);
         chk($sformatf("bp_no_grant_%0d", k), 64'(m_arready), 64'd0);
         tick();
      end
      settle();
      chk("bp_data_sarvalid", 64'(s_arvalid), 64'd0);
      chk("bp_data_rvalid", 64'(m_rvalid), 64'b0001);
      tick();
      settle();
      chk("bp_second_grant", 64'(m_arready), 64'b0010);
      tick();
      m_arvalid = '0;
      wait_drain("bp_drain");

      // Requester R backpressure on master 1 with SLVERR.
      do_reset();
      set_addr(1, 32'h24);
      s_arready = 1'b1; s_rvalid = 1'b1; s_rresp = 2'b10; m_rready = 4'b1101;
      rvalid0_cycles = 0;
      expect_txn(1, 2'b10, 1'b1);
      m_arvalid = 4'b0010;
      settle();
      chk("rbp_grant", 64'(m_arready), 64'b0010);
      tick();
      m_arvalid = '0;
      settle();
      chk("rbp_addr_phase", 64'(s_arvalid), 64'd1);
      tick();
      for (int k = 0; k < 3; k++) begin
         settle();
         chk($sformatf("rbp_srready_%0d", k), 64'(s_rready), 64'd0);
         chk($sformatf("rbp_rvalid_%0d", k), 64'(m_rvalid), 64'b0010);
         chk($sformatf("rbp_busy_%0d", k), 64'(busy), 64'd1);
         tick();
      end
      m_rready = '1;
      settle();
      chk("rbp_release_srready", 64'(s_rready), 64'd1);
      chk("rbp_rresp1", 64'(m_rresp[3:2]), 64'b10);
      tick();
      settle();
      chk("rbp_idle", 64'(busy), 64'd0);
      chk("rbp_rvalid0_never", 64'(rvalid0_cycles), 64'd0);
      wait_drain("rbp_drain");

      // Reset while master 1 is stalled in DATA; master 0 must win afterwards.
      do_reset();
      set_addr(0, 32'h60); set_addr(1, 32'h64);
      s_arready = 1'b1; s_rvalid = 1'b1; s_rresp = 2'b00; m_rready = '1;
      expect_txn(0, 2'b00, 1'b1);
      m_arvalid = 4'b0001;
      tick();
      m_arvalid = '0;
      wait_drain("rstd_first_drain");
      m_rready = 4'b1101;
      expect_txn(1, 2'b00, 1'b0);
      m_arvalid = 4'b0010;
      tick();
      m_arvalid = '0;
      tick();
      settle();
      chk("rstd_in_data", 64'(busy), 64'd1);
      chk("rstd_rvalid", 64'(m_rvalid), 64'b0010);
      areset = 1'b1;
      m_arvalid = 4'b0011;
      #1;
      chk("rstd_gate_srready", 64'(s_rready), 64'd0);
      chk("rstd_gate_rvalid", 64'(m_rvalid), 64'd0);
      chk("rstd_gate_arready", 64'(m_arready), 64'd0);
      tick();
      areset = 1'b0;
      m_rready = '1;
      expect_txn(0, 2'b00, 1'b1);
      settle();
      chk("rstd_busy", 64'(busy), 64'd0);
      chk("rstd_srready", 64'(s_rready), 64'd0);
      chk("rstd_sarvalid", 64'(s_arvalid), 64'd0);
      chk("rstd_winner", 64'(m_arready), 64'b0001);
      tick();
      m_arvalid = '0;
      wait_drain("rstd_drain");

      // Four masters: 0,1,2,3,0 then master 2 drops -> 1,3,0.
      do_reset();
      for (int i = 0; i < N; i++) set_addr(i, 32'h100 * (i + 1));
      s_arready = 1'b1; s_rvalid = 1'b1; s_rresp = 2'b00; m_rready = '1;
      expect_txn(0, 2'b00, 1'b1); expect_txn(1, 2'b00, 1'b1);
      expect_txn(2, 2'b00, 1'b1); expect_txn(3, 2'b00, 1'b1);
      expect_txn(0, 2'b00, 1'b1); expect_txn(1, 2'b00, 1'b1);
      expect_txn(3, 2'b00, 1'b1); expect_txn(0, 2'b00, 1'b1);
      run_rr(8, 4'b1111, 2);
      wait_drain("rr4_drain");

      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
